// File: rtl/io_input_conditioner.sv
// Synchronises and debounces 4 active-low keys and 10 switches onto io_input_bus.
// Optional IO_KEY_EDGE_EN adds a registered one-cycle key_press_pulse per debounced press.
module io_debounce_lane #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_WIDTH       = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Any return to the stable level restarts the count, so glitches never accumulate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            stable <= RST_VAL;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

module io_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  key_n_in,
    input  logic [9:0]  sw_in,
    output logic [13:0] io_input_bus,
    output logic [3:0]  key_press_pulse
);
    // Keys idle high (released), switches idle low.
    localparam logic [13:0] LANE_RST = {4'hF, 10'h000};

    logic [13:0] raw;
    logic [13:0] stable;

    assign raw = {key_n_in, sw_in};

    for (genvar i = 0; i < 14; i++) begin : g_lane
        io_debounce_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH),
            .RST_VAL        (LANE_RST[i])
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .raw    (raw[i]),
            .stable (stable[i])
        );
    end

    assign io_input_bus = {~stable[13:10], stable[9:0]};

`ifdef IO_KEY_EDGE_EN
    logic [3:0] key_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_prev        <= 4'b0;
            key_press_pulse <= 4'b0;
        end else begin
            key_prev        <= io_input_bus[13:10];
            key_press_pulse <= io_input_bus[13:10] & ~key_prev;
        end
    end
`else
    assign key_press_pulse = 4'b0;
`endif
endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Expected key_press_pulse depends on whether IO_KEY_EDGE_EN is defined.
module tb_io_input_conditioner;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  key_n_in;
    logic [9:0]  sw_in;
    logic [13:0] io_input_bus;
    logic [3:0]  key_press_pulse;

    int total = 0;
    int bad   = 0;

`ifdef IO_KEY_EDGE_EN
    localparam logic [3:0] PRESS_PULSE = 4'b0100;
`else
    localparam logic [3:0] PRESS_PULSE = 4'b0000;
`endif

    io_input_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (16)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .key_n_in       (key_n_in),
        .sw_in          (sw_in),
        .io_input_bus   (io_input_bus),
        .key_press_pulse(key_press_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        key_n_in = 4'hF;
        sw_in    = 10'h000;
        #1;
        chk("reset_bus_t0", 16'(io_input_bus), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_bus", 16'(io_input_bus), 16'h0000);
            chk("reset_pulse", 16'(key_press_pulse), 16'h0000);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_reset_bus", 16'(io_input_bus), 16'h0000);
        end

        // Switch 3 rises exactly at edge 6.
        sw_in[3] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sw3_wait", 16'(io_input_bus), 16'h0000);
        end
        step();
        chk("sw3_rise", 16'(io_input_bus), 16'h0008);

        // Two 3-cycle key 0 glitches back to back: neither is accepted.
        for (int g = 0; g < 2; g++) begin
            key_n_in[0] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("key0_glitch_low", 16'(io_input_bus), 16'h0008);
            end
            key_n_in[0] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                step();
                chk("key0_glitch_high", 16'(io_input_bus), 16'h0008);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk("key0_settled", 16'(io_input_bus), 16'h0008);
        end

        // Key 2 press: bus bit 12 at edge 6, pulse on the following cycle only.
        key_n_in[2] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("key2_wait", 16'(io_input_bus), 16'h0008);
            chk("key2_wait_pulse", 16'(key_press_pulse), 16'h0000);
        end
        step();
        chk("key2_rise", 16'(io_input_bus), 16'h1008);
        chk("key2_rise_pulse", 16'(key_press_pulse), 16'h0000);
        step();
        chk("key2_pulse", 16'(key_press_pulse), 16'(PRESS_PULSE));
        step();
        chk("key2_pulse_end", 16'(key_press_pulse), 16'h0000);
        chk("key2_held", 16'(io_input_bus), 16'h1008);

        // Release: bit falls at edge 6, no pulse anywhere.
        key_n_in[2] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("key2_rel_wait", 16'(io_input_bus), 16'h1008);
            chk("key2_rel_pulse", 16'(key_press_pulse), 16'h0000);
        end
        step();
        chk("key2_released", 16'(io_input_bus), 16'h0008);
        step();
        chk("key2_rel_no_pulse", 16'(key_press_pulse), 16'h0000);

        // Switch 0 toggles every 2 cycles (1,1,0,0,...) for 40 cycles, ending low.
        for (int i = 0; i < 40; i++) begin
            sw_in[0] = ~((i / 2) % 2 == 1);
            step();
            chk("sw0_toggle", 16'(io_input_bus), 16'h0008);
        end
        sw_in[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sw0_hold_wait", 16'(io_input_bus), 16'h0008);
        end
        step();
        chk("sw0_hold_rise", 16'(io_input_bus), 16'h0009);

        // Switch 5 count reaches 3 of 4, then reset discards it.
        sw_in[5] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sw5_partial", 16'(io_input_bus), 16'h0009);
        end
        reset = 1'b1;
        #1;
        chk("midcount_reset_bus", 16'(io_input_bus), 16'h0000);
        chk("midcount_reset_pulse", 16'(key_press_pulse), 16'h0000);
        step();
        step();
        chk("midcount_reset_hold", 16'(io_input_bus), 16'h0000);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("post_reset_wait", 16'(io_input_bus), 16'h0000);
        end
        step();
        chk("post_reset_rise", 16'(io_input_bus), 16'h0029);
        chk("post_reset_pulse", 16'(key_press_pulse), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
